// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction-fetch stage: PC, imem address, IF/ID register
//
// Owns the program counter, presents it combinationally as the instruction
// ROM address and captures the returned word into the IF/ID register.
// Redirects flush IF/ID; a misaligned redirect target halts fetch until reset.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous active-high reset
//   stall            hold PC and IF/ID this cycle
//   redirect_valid   taken branch/jump resolved this cycle
//   redirect_target  new PC when redirect_valid=1
//   imem_addr        instruction ROM address (= pc)
//   imem_insn        ROM read data, same cycle
//   if_id_insn       registered instruction to decode
//   if_id_pc         PC of if_id_insn
//   if_id_valid      if_id_insn is a real fetched instruction
//   fetch_fault      sticky misaligned-redirect flag
//   fetch_count      instructions captured into IF/ID (wraps)
module fetch_stage #(
   parameter int                     ADDR_WIDTH = 32,
   parameter int                     WORD_SIZE  = 32,
   parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = 32'h0000_0000,
   parameter logic [WORD_SIZE-1:0]   NOP_INSN   = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_target,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [WORD_SIZE-1:0]  imem_insn,
   output logic [WORD_SIZE-1:0]  if_id_insn,
   output logic [ADDR_WIDTH-1:0] if_id_pc,
   output logic                  if_id_valid,
   output logic                  fetch_fault,
   output logic [31:0]           fetch_count
);

   typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

   localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

   state_t                r_state, w_nxt_state;
   logic [ADDR_WIDTH-1:0] r_pc, w_nxt_pc;
   logic [WORD_SIZE-1:0]  r_insn, w_nxt_insn;
   logic [ADDR_WIDTH-1:0] r_if_pc, w_nxt_if_pc;
   logic                  r_valid, w_nxt_valid;
   logic                  r_fault, w_nxt_fault;
   logic [31:0]           r_count, w_nxt_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_RUN;
         r_pc    <= RESET_PC;
         r_insn  <= NOP_INSN;
         r_if_pc <= '0;
         r_valid <= 1'b0;
         r_fault <= 1'b0;
         r_count <= 32'd0;
      end else begin
         r_state <= w_nxt_state;
         r_pc    <= w_nxt_pc;
         r_insn  <= w_nxt_insn;
         r_if_pc <= w_nxt_if_pc;
         r_valid <= w_nxt_valid;
         r_fault <= w_nxt_fault;
         r_count <= w_nxt_count;
      end
   end

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_pc    = r_pc;
      w_nxt_insn  = r_insn;
      w_nxt_if_pc = r_if_pc;
      w_nxt_valid = r_valid;
      w_nxt_fault = r_fault;
      w_nxt_count = r_count;
      case (r_state)
         S_RUN: begin
            if (redirect_valid) begin
               // Redirect beats stall: the instruction in IF/ID is on the
               // wrong path either way, so it is always flushed.
               w_nxt_insn  = NOP_INSN;
               w_nxt_if_pc = '0;
               w_nxt_valid = 1'b0;
               if (redirect_target[1:0] == 2'b00) begin
                  w_nxt_pc = redirect_target;
               end else begin
                  // Misaligned target: keep pc, latch the fault, stop fetching.
                  w_nxt_fault = 1'b1;
                  w_nxt_state = S_HALT;
               end
            end else if (!stall) begin
               w_nxt_insn  = imem_insn;
               w_nxt_if_pc = r_pc;
               w_nxt_valid = 1'b1;
               w_nxt_pc    = r_pc + PC_STEP;
               w_nxt_count = r_count + 32'd1;
            end
         end
         S_HALT: begin
            // Only reset leaves HALT; keep a bubble in IF/ID.
            w_nxt_insn  = NOP_INSN;
            w_nxt_if_pc = '0;
            w_nxt_valid = 1'b0;
            w_nxt_fault = 1'b1;
         end
      endcase
   end

   assign imem_addr   = r_pc;
   assign if_id_insn  = r_insn;
   assign if_id_pc    = r_if_pc;
   assign if_id_valid = r_valid;
   assign fetch_fault = r_fault;
   assign fetch_count = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard testbench for fetch_stage
module tb_fetch_stage;

   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] RPC2  = 32'hFFFF_FFF8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rst2 = 1'b1;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = 32'd0;
   logic [31:0] imem_addr, imem_insn, if_id_insn, if_id_pc, fetch_count;
   logic        if_id_valid, fetch_fault;

   logic [31:0] imem_addr2, imem_insn2, if_id_insn2, if_id_pc2, fetch_count2;
   logic        if_id_valid2, fetch_fault2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      if (a == 32'h4) return 32'h00A0_0113;
      return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   assign imem_insn  = rom(imem_addr);
   assign imem_insn2 = rom(imem_addr2);

   fetch_stage u_dut (
      .clk(clk), .rst(rst), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .imem_addr(imem_addr), .imem_insn(imem_insn),
      .if_id_insn(if_id_insn), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
      .fetch_fault(fetch_fault), .fetch_count(fetch_count)
   );

   fetch_stage #(.RESET_PC(RPC2)) u_dut2 (
      .clk(clk), .rst(rst2), .stall(1'b0),
      .redirect_valid(1'b0), .redirect_target(32'd0),
      .imem_addr(imem_addr2), .imem_insn(imem_insn2),
      .if_id_insn(if_id_insn2), .if_id_pc(if_id_pc2), .if_id_valid(if_id_valid2),
      .fetch_fault(fetch_fault2), .fetch_count(fetch_count2)
   );

   typedef struct {
      logic [31:0] insn;
      logic [31:0] ifpc;
      logic        valid;
      logic [31:0] addr;
      logic [31:0] count;
      logic        fault;
   } exp_t;

   exp_t exp_q[$];

   // reference model state
   logic [31:0] m_pc, m_insn, m_ifpc, m_count;
   logic        m_valid, m_fault, m_halt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_insn = NOP; m_ifpc = 32'h0; m_count = 32'h0;
      m_valid = 1'b0; m_fault = 1'b0; m_halt = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_addr"},  imem_addr, 32'h0);
      chk({tag, "_insn"},  if_id_insn, NOP);
      chk({tag, "_ifpc"},  if_id_pc, 32'h0);
      chk({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
      chk({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
      chk({tag, "_count"}, fetch_count, 32'd0);
   endtask

   // Drive one cycle of stimulus, push the model's expectation, then pop and
   // compare one edge later.
   task automatic cycle(input logic st, input logic rv, input logic [31:0] tgt, input string tag);
      exp_t e;
      exp_t o;
      stall = st; redirect_valid = rv; redirect_target = tgt;
      if (!m_halt) begin
         if (rv) begin
            m_insn = NOP; m_ifpc = 32'h0; m_valid = 1'b0;
            if (tgt[1:0] == 2'b00) m_pc = tgt;
            else begin m_fault = 1'b1; m_halt = 1'b1; end
         end else if (!st) begin
            m_insn = rom(m_pc); m_ifpc = m_pc; m_valid = 1'b1;
            m_pc = m_pc + 32'd4; m_count = m_count + 32'd1;
         end
      end
      e.insn = m_insn; e.ifpc = m_ifpc; e.valid = m_valid;
      e.addr = m_pc; e.count = m_count; e.fault = m_fault;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
         o = exp_q.pop_front();
         chk({tag, "_insn"},  if_id_insn, o.insn);
         chk({tag, "_ifpc"},  if_id_pc, o.ifpc);
         chk({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, o.valid});
         chk({tag, "_addr"},  imem_addr, o.addr);
         chk({tag, "_count"}, fetch_count, o.count);
         chk({tag, "_fault"}, {31'd0, fetch_fault}, {31'd0, o.fault});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      @(posedge clk); #1;
      check_reset_vals("rst_hold");

      // Second instance runs across the address wrap while dut 1 sits in reset.
      chk("w_addr0", imem_addr2, RPC2);
      rst2 = 1'b0;
      @(posedge clk); #1;
      chk("w_ifpc1", if_id_pc2, 32'hFFFF_FFF8);
      chk("w_insn1", if_id_insn2, rom(32'hFFFF_FFF8));
      chk("w_addr1", imem_addr2, 32'hFFFF_FFFC);
      @(posedge clk); #1;
      chk("w_ifpc2", if_id_pc2, 32'hFFFF_FFFC);
      chk("w_addr2", imem_addr2, 32'h0000_0000);
      @(posedge clk); #1;
      chk("w_ifpc3", if_id_pc2, 32'h0000_0000);
      chk("w_valid", {31'd0, if_id_valid2}, 32'd1);
      chk("w_fault", {31'd0, fetch_fault2}, 32'd0);
      chk("w_count", fetch_count2, 32'd3);
      check_reset_vals("rst_hold2");

      rst = 1'b0;
      cycle(0, 0, 0, "adv1");
      cycle(0, 0, 0, "adv2");
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, "stall");
      cycle(0, 0, 0, "unstall");
      cycle(1, 1, 32'h40, "redir_stall");
      cycle(0, 0, 0, "after_redir");
      cycle(0, 0, 0, "adv3");
      cycle(0, 1, m_pc, "redir_self");
      cycle(0, 0, 0, "adv4");
      for (int i = 0; i < 4; i++) cycle($urandom_range(0, 1) == 1, 0, 0, "mix");
      cycle(0, 1, 32'h0000_0100, "redir_100");
      cycle(0, 0, 0, "adv5");
      cycle(0, 1, 32'h42, "misalign");
      cycle(0, 1, 32'h80, "halt_redir");
      cycle(1, 0, 0, "halt_stall");
      cycle(0, 0, 0, "halt_adv");

      // synchronous-looking reset pulse out of HALT
      rst = 1'b1; #1;
      check_reset_vals("rst_pulse");
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      cycle(0, 0, 0, "post_rst1");
      cycle(0, 0, 0, "post_rst2");

      // async reset during a redirect cycle, checked before the next edge
      stall = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h200;
      #2;
      rst = 1'b1;
      #1;
      check_reset_vals("async");
      rst = 1'b0;
      redirect_valid = 1'b0;
      model_reset();
      cycle(0, 0, 0, "post_async1");
      cycle(0, 0, 0, "post_async2");

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
